hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the five-stage RV32 core. It sequences the fetch, decode, execute and memory stage registers. It generates:
- execute-stage operand forwarding selects,
- load-use stalls,
- branch/jump flushes,
- whole-pipeline freezes while the data memory is not ready, with timeout detection.

It also keeps saturating stall and redirect performance counters.

---
 rtl/hazard_if.sv | 44 ++++
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_if.sv
// Hazard controller bundle: pipeline-side register ids and enables,
// controller-side forwarding, stall, flush and status outputs.
interface hazard_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [1:0]       ResultSrcE;
    logic             PCSrcE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemAccessM;
    logic             dmem_ready;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             FlushD;
    logic             FlushE;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
        output RdM, RdW, RegWriteM, RegWriteW, MemAccessM, dmem_ready,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        input  FlushD, FlushE, mem_err, stall_cnt, redirect_cnt
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, ResultSrcE, PCSrcE,
        input  RdM, RdW, RegWriteM, RegWriteW, MemAccessM, dmem_ready,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
        output FlushD, FlushE, mem_err, stall_cnt, redirect_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage RV32 hazard unit: forwarding, load-use stall, redirect
// flush, memory-wait freeze with timeout, saturating perf counters.
module hazard_ctrl #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic    clk,
    input  logic    rst,
    hazard_if.slave hz
);
    localparam int WCW = $clog2(TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

    localparam logic [1:0] S_RUN  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ERR  = 2'd2;

    logic [1:0]       r_state;
    logic [WCW-1:0]   r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_redirect_cnt;

    logic       w_lw_stall;
    logic       w_freeze;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    always_comb begin
        w_fwd_a = 2'b00;
        if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs1E)
            w_fwd_a = 2'b10;
        else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs1E)
            w_fwd_a = 2'b01;
    end

    always_comb begin
        w_fwd_b = 2'b00;
        if (hz.RegWriteM && hz.RdM != 5'd0 && hz.RdM == hz.Rs2E)
            w_fwd_b = 2'b10;
        else if (hz.RegWriteW && hz.RdW != 5'd0 && hz.RdW == hz.Rs2E)
            w_fwd_b = 2'b01;
    end

    // A redirect squashes the decode instruction, so no load-use stall.
    assign w_lw_stall = (hz.ResultSrcE == 2'b01) && (hz.RdE != 5'd0) &&
                        ((hz.RdE == hz.Rs1D) || (hz.RdE == hz.Rs2D)) &&
                        !hz.PCSrcE;

    assign w_freeze = (r_state == S_WAIT && !hz.dmem_ready) ||
                      (r_state == S_RUN && hz.MemAccessM && !hz.dmem_ready) ||
                      (r_state == S_ERR);

    assign hz.ForwardAE    = w_fwd_a;
    assign hz.ForwardBE    = w_fwd_b;
    assign hz.StallF       = w_freeze | w_lw_stall;
    assign hz.StallD       = w_freeze | w_lw_stall;
    assign hz.StallE       = w_freeze;
    assign hz.StallM       = w_freeze;
    assign hz.FlushD       = !w_freeze && hz.PCSrcE;
    assign hz.FlushE       = !w_freeze && (w_lw_stall || hz.PCSrcE);
    assign hz.mem_err      = r_mem_err;
    assign hz.stall_cnt    = r_stall_cnt;
    assign hz.redirect_cnt = r_redirect_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (hz.MemAccessM && !hz.dmem_ready) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= WCW'(1);
                    end
                end
                S_WAIT: begin
                    if (hz.dmem_ready) begin
                        r_state <= S_RUN;
                    end else if (r_wait_cnt == WAIT_LAST) begin
                        r_state   <= S_ERR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + WCW'(1);
                    end
                end
                S_ERR: begin
                    r_state <= S_ERR;
                end
                default: begin
                    r_state <= S_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt    <= '0;
            r_redirect_cnt <= '0;
        end else begin
            if (hz.StallF && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if (hz.PCSrcE && !w_freeze && !(&r_redirect_cnt))
                r_redirect_cnt <= r_redirect_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Vector table plus hand-written multi-cycle sequences for hazard_ctrl,
// with expected outputs queued at drive time and popped at sample time.
module tb_hazard_ctrl;
    localparam int TO = 4;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    hazard_if #(.CNT_W(CW)) hz ();

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .hz (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde;
        logic [1:0] rsrc;
        logic       pc;
        logic [4:0] rdm, rdw;
        logic       rwm, rww, mema, rdy;
        logic [9:0] exp;
        string      name;
    } vec_t;

    localparam logic [9:0] FRZ = 10'b00_00_1111_00;

    vec_t vecs[13];
    logic [9:0] sb_q[$];
    string      nm_q[$];
    int n_chk = 0;
    int n_pass = 0;

    function automatic logic [9:0] outs();
        return {hz.ForwardAE, hz.ForwardBE, hz.StallF, hz.StallD,
                hz.StallE, hz.StallM, hz.FlushD, hz.FlushE};
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    task automatic push(input logic [9:0] e, input string nm);
        sb_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic pop_cmp();
        logic [9:0] e;
        string nm;
        logic [9:0] a;
        a = outs();
        n_chk++;
        if (sb_q.size() == 0) begin
            $display("FAIL scoreboard: empty queue, got %b", a);
        end else begin
            e  = sb_q.pop_front();
            nm = nm_q.pop_front();
            if (a == e) n_pass++;
            else $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    task automatic clr();
        hz.Rs1D = 0; hz.Rs2D = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RdE = 0;
        hz.ResultSrcE = 0; hz.PCSrcE = 0; hz.RdM = 0; hz.RdW = 0;
        hz.RegWriteM = 0; hz.RegWriteW = 0;
        hz.MemAccessM = 0; hz.dmem_ready = 0;
    endtask

    task automatic apply(input vec_t v);
        hz.Rs1D = v.rs1d; hz.Rs2D = v.rs2d; hz.Rs1E = v.rs1e;
        hz.Rs2E = v.rs2e; hz.RdE = v.rde; hz.ResultSrcE = v.rsrc;
        hz.PCSrcE = v.pc; hz.RdM = v.rdm; hz.RdW = v.rdw;
        hz.RegWriteM = v.rwm; hz.RegWriteW = v.rww;
        hz.MemAccessM = v.mema; hz.dmem_ready = v.rdy;
    endtask

    task automatic do_reset(input string nm);
        clr();
        @(negedge clk);
        rst = 1'b1;
        #1;
        push(10'd0, {nm, "_out"});
        pop_cmp();
        chk({nm, "_mem_err"}, int'(hz.mem_err), 0);
        chk({nm, "_stall_cnt"}, int'(hz.stall_cnt), 0);
        chk({nm, "_redir_cnt"}, int'(hz.redirect_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{0,0,0,0,0, 2'b00,0, 0,0, 0,0,0,0,
                     10'b00_00_0000_00, "idle"};
        vecs[1]  = '{0,0,5,5,0, 2'b00,0, 5,5, 1,1,0,0,
                     10'b10_10_0000_00, "fwd_mem_pri"};
        vecs[2]  = '{0,0,5,5,0, 2'b00,0, 0,5, 1,1,0,0,
                     10'b01_01_0000_00, "fwd_wb"};
        vecs[3]  = '{0,0,0,5,0, 2'b00,0, 0,0, 1,1,0,0,
                     10'b00_00_0000_00, "fwd_none"};
        vecs[4]  = '{0,0,3,4,0, 2'b00,0, 3,4, 1,1,0,0,
                     10'b10_01_0000_00, "fwd_mix"};
        vecs[5]  = '{0,0,3,4,0, 2'b00,0, 3,4, 0,0,0,0,
                     10'b00_00_0000_00, "fwd_nowe"};
        vecs[6]  = '{0,7,0,0,7, 2'b01,0, 0,0, 0,0,0,0,
                     10'b00_00_1100_01, "lduse_rs2"};
        vecs[7]  = '{0,0,0,0,0, 2'b01,0, 0,0, 0,0,0,0,
                     10'b00_00_0000_00, "lduse_x0"};
        vecs[8]  = '{7,0,0,0,7, 2'b10,0, 0,0, 0,0,0,0,
                     10'b00_00_0000_00, "nonload"};
        vecs[9]  = '{0,7,0,0,7, 2'b01,1, 0,0, 0,0,0,0,
                     10'b00_00_0000_11, "lduse_redir"};
        vecs[10] = '{0,0,0,0,0, 2'b00,1, 0,0, 0,0,0,0,
                     10'b00_00_0000_11, "redir"};
        vecs[11] = '{0,0,0,0,0, 2'b00,1, 0,0, 0,0,1,1,
                     10'b00_00_0000_11, "mem_ready1"};
        vecs[12] = '{7,0,0,0,7, 2'b01,0, 0,0, 0,0,0,0,
                     10'b00_00_1100_01, "lduse_rs1"};

        clr();
        #2;
        push(10'd0, "in_reset_out");
        pop_cmp();
        chk("in_reset_mem_err", int'(hz.mem_err), 0);
        do_reset("rst0");

        for (int i = 0; i < 13; i++) begin
            @(posedge clk); #1;
            apply(vecs[i]);
            push(vecs[i].exp, vecs[i].name);
            @(negedge clk);
            pop_cmp();
        end
        @(posedge clk); #1;
        clr();
        chk("vec_stall_cnt", int'(hz.stall_cnt), 2);
        chk("vec_redir_cnt", int'(hz.redirect_cnt), 3);
        chk("vec_mem_err", int'(hz.mem_err), 0);

        do_reset("rst_wait");
        @(posedge clk); #1;
        hz.MemAccessM = 1; hz.dmem_ready = 0; hz.PCSrcE = 1;
        for (int k = 0; k < 3; k++) begin
            push(FRZ, $sformatf("wait_frz%0d", k));
            @(negedge clk);
            pop_cmp();
            @(posedge clk); #1;
        end
        hz.dmem_ready = 1;
        push(10'b00_00_0000_11, "wait_release");
        @(negedge clk);
        pop_cmp();
        @(posedge clk); #1;
        clr();
        chk("wait_stall_cnt", int'(hz.stall_cnt), 3);
        chk("wait_redir_cnt", int'(hz.redirect_cnt), 1);
        chk("wait_mem_err", int'(hz.mem_err), 0);
        hz.MemAccessM = 1; hz.dmem_ready = 1;
        push(10'd0, "wait_back_run");
        @(negedge clk);
        pop_cmp();

        do_reset("rst_to");
        @(posedge clk); #1;
        hz.MemAccessM = 1; hz.dmem_ready = 0;
        for (int k = 1; k <= TO; k++) begin
            @(posedge clk); #1;
            chk($sformatf("to_mem_err_e%0d", k), int'(hz.mem_err),
                (k == TO) ? 1 : 0);
        end
        chk("to_stall_cnt", int'(hz.stall_cnt), TO);
        hz.MemAccessM = 0; hz.dmem_ready = 1; hz.PCSrcE = 1;
        push(FRZ, "to_frz_persist");
        @(negedge clk);
        pop_cmp();
        @(posedge clk); #1;
        chk("to_redir_cnt", int'(hz.redirect_cnt), 0);
        chk("to_mem_err_hold", int'(hz.mem_err), 1);
        hz.PCSrcE = 0;
        #2;
        rst = 1'b1;
        #1;
        push(10'd0, "to_rst_out");
        pop_cmp();
        chk("to_rst_mem_err", int'(hz.mem_err), 0);
        chk("to_rst_stall_cnt", int'(hz.stall_cnt), 0);
        chk("to_rst_redir_cnt", int'(hz.redirect_cnt), 0);
        @(negedge clk);
        rst = 1'b0;

        do_reset("rst_sat");
        @(posedge clk); #1;
        hz.ResultSrcE = 2'b01; hz.RdE = 7; hz.Rs1D = 7;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
        end
        clr();
        chk("sat_stall_cnt", int'(hz.stall_cnt), 15);
        @(posedge clk); #1;
        chk("sat_stall_hold", int'(hz.stall_cnt), 15);
        chk("sat_redir_cnt", int'(hz.redirect_cnt), 0);

        n_chk++;
        if (sb_q.size() == 0) n_pass++;
        else $display("FAIL sb_leftover: got %0d expected 0", sb_q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
